fifo_16to8: RTL and testbench



---
 rtl/fifo_16to8_pkg.sv | 24 ++
 rtl/fifo_16to8_ram.sv | 32 +++
 rtl/fifo_16to8.sv | 114 +++++++++++
 tb/tb_fifo_16to8.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_16to8_pkg.sv
// Shared widths, depths and default thresholds for the 16-bit-in / 8-bit-out FIFO.
package fifo_16to8_pkg;

    localparam int unsigned WR_WIDTH = 16;
    localparam int unsigned RD_WIDTH = 8;
    localparam int unsigned WR_DEPTH = 512;
    localparam int unsigned RD_DEPTH = 1024;

    localparam int unsigned PTR_W    = $clog2(WR_DEPTH);
    localparam int unsigned WORDS_W  = PTR_W + 1;
    localparam int unsigned BYTES_W  = WORDS_W + 1;
    localparam int unsigned WR_CNT_W = PTR_W;
    localparam int unsigned RD_CNT_W = $clog2(RD_DEPTH);

    localparam int unsigned DEF_PROG_FULL_THRESH  = 500;
    localparam int unsigned DEF_PROG_EMPTY_THRESH = 8;

    // A word whose upper byte has been consumed contributes only one readable byte.
    function automatic logic [BYTES_W-1:0] words_to_bytes(input logic [WORDS_W-1:0] words,
                                                          input logic sel);
        return {words, 1'b0} - BYTES_W'(sel);
    endfunction

endpackage

// File: rtl/fifo_16to8_ram.sv
// Simple dual-port 512x16 RAM: synchronous write, registered read with cleared output register.
module fifo_16to8_ram
    import fifo_16to8_pkg::*;
(
    input  logic                clk,
    input  logic                srst,
    input  logic                wr_en,
    input  logic [PTR_W-1:0]    wr_addr,
    input  logic [WR_WIDTH-1:0] wr_data,
    input  logic                rd_en,
    input  logic [PTR_W-1:0]    rd_addr,
    output logic [WR_WIDTH-1:0] rd_data
);

    logic [WR_WIDTH-1:0] mem [WR_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds between reads so the consumer sees a stable byte.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_16to8.sv
// Width-converting FIFO: 16-bit words in, bytes out (upper byte first), standard read mode.
module fifo_16to8
    import fifo_16to8_pkg::*;
#(
    parameter int unsigned PROG_FULL_THRESH  = DEF_PROG_FULL_THRESH,
    parameter int unsigned PROG_EMPTY_THRESH = DEF_PROG_EMPTY_THRESH
) (
    input  logic                clk,
    input  logic                srst,
    input  logic [WR_WIDTH-1:0] din,
    input  logic                wr_en,
    input  logic                rd_en,
    output logic [RD_WIDTH-1:0] dout,
    output logic                full,
    output logic                almost_full,
    output logic                wr_ack,
    output logic                overflow,
    output logic                empty,
    output logic                almost_empty,
    output logic                valid,
    output logic                underflow,
    output logic [RD_CNT_W-1:0] rd_data_count,
    output logic [WR_CNT_W-1:0] wr_data_count,
    output logic                prog_full,
    output logic                prog_empty
);

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                sel_q, sel_d;
    logic [WORDS_W-1:0]  words_q, words_d;
    logic [BYTES_W-1:0]  bytes_d;
    logic                byte_lo_q;
    logic                wr_accept, rd_accept, word_done;
    logic [WR_WIDTH-1:0] ram_rd_data;

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;
    assign word_done = rd_accept && sel_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sel_d    = sel_q;
        words_d  = words_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            sel_d = !sel_q;
            if (sel_q) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
        words_d = words_q + WORDS_W'(wr_accept) - WORDS_W'(word_done);
        bytes_d = words_to_bytes(words_d, sel_d);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sel_q         <= 1'b0;
            words_q       <= '0;
            byte_lo_q     <= 1'b0;
            full          <= 1'b0;
            almost_full   <= 1'b0;
            prog_full     <= 1'b0;
            empty         <= 1'b1;
            almost_empty  <= 1'b1;
            prog_empty    <= 1'b1;
            wr_ack        <= 1'b0;
            overflow      <= 1'b0;
            valid         <= 1'b0;
            underflow     <= 1'b0;
            rd_data_count <= '0;
            wr_data_count <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            sel_q         <= sel_d;
            words_q       <= words_d;
            if (rd_accept) begin
                byte_lo_q <= sel_q;
            end
            full          <= (words_d == WORDS_W'(WR_DEPTH));
            almost_full   <= (words_d >= WORDS_W'(WR_DEPTH - 1));
            prog_full     <= (words_d >= WORDS_W'(PROG_FULL_THRESH));
            empty         <= (bytes_d == '0);
            almost_empty  <= (bytes_d <= BYTES_W'(1));
            prog_empty    <= (bytes_d <= BYTES_W'(PROG_EMPTY_THRESH));
            wr_ack        <= wr_accept;
            overflow      <= wr_en && full;
            valid         <= rd_accept;
            underflow     <= rd_en && empty;
            rd_data_count <= bytes_d[RD_CNT_W-1:0];
            wr_data_count <= words_d[WR_CNT_W-1:0];
        end
    end

    fifo_16to8_ram u_ram (
        .clk     (clk),
        .srst    (srst),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (din),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    assign dout = byte_lo_q ? ram_rd_data[7:0] : ram_rd_data[15:8];

endmodule

// File: tb/tb_fifo_16to8.sv
// Directed bench for fifo_16to8 with immediate-assertion checks.
module tb_fifo_16to8;

    logic        clk = 1'b0;
    logic        srst;
    logic [15:0] din;
    logic        wr_en, rd_en;
    logic [7:0]  dout;
    logic        full, almost_full, wr_ack, overflow;
    logic        empty, almost_empty, valid, underflow;
    logic [9:0]  rd_data_count;
    logic [8:0]  wr_data_count;
    logic        prog_full, prog_empty;

    int n_cmp = 0;
    int n_err = 0;

    fifo_16to8 dut (
        .clk           (clk),
        .srst          (srst),
        .din           (din),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .dout          (dout),
        .full          (full),
        .almost_full   (almost_full),
        .wr_ack        (wr_ack),
        .overflow      (overflow),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .valid         (valid),
        .underflow     (underflow),
        .rd_data_count (rd_data_count),
        .wr_data_count (wr_data_count),
        .prog_full     (prog_full),
        .prog_empty    (prog_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " empty"}, 32'(empty), 32'd1);
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
        chk({tag, " prog_empty"}, 32'(prog_empty), 32'd1);
        chk({tag, " full/af/pf"}, {29'd0, full, almost_full, prog_full}, 32'd0);
        chk({tag, " ack/ovf/val/udf"}, {28'd0, wr_ack, overflow, valid, underflow}, 32'd0);
        chk({tag, " rd_cnt"}, 32'(rd_data_count), 32'd0);
        chk({tag, " wr_cnt"}, 32'(wr_data_count), 32'd0);
        chk({tag, " dout"}, 32'(dout), 32'd0);
    endtask

    task automatic do_reset();
        srst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        tick();
        srst = 1'b0;
    endtask

    function automatic logic [15:0] fill_word(input int i);
        return 16'((i * 773) ^ 16'hC35A);
    endfunction

    initial begin
        logic [15:0] w;
        logic [7:0]  b;
        srst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;

        // 1. Reset held 10 cycles
        for (int i = 0; i < 10; i++) tick();
        chk_reset_state("reset");
        srst = 1'b0;

        // 2. Byte order
        wr_en = 1'b1; din = 16'h1234;
        tick();
        wr_en = 1'b0;
        chk("bo wr_ack", 32'(wr_ack), 32'd1);
        chk("bo empty", 32'(empty), 32'd0);
        chk("bo rd_cnt2", 32'(rd_data_count), 32'd2);
        rd_en = 1'b1;
        tick();
        chk("bo dout hi", 32'(dout), 32'h12);
        chk("bo valid1", 32'(valid), 32'd1);
        chk("bo rd_cnt1", 32'(rd_data_count), 32'd1);
        chk("bo wr_cnt1", 32'(wr_data_count), 32'd1);
        chk("bo almost_empty1", 32'(almost_empty), 32'd1);
        tick();
        rd_en = 1'b0;
        chk("bo dout lo", 32'(dout), 32'h34);
        chk("bo valid2", 32'(valid), 32'd1);
        chk("bo empty2", 32'(empty), 32'd1);
        chk("bo almost_empty2", 32'(almost_empty), 32'd1);

        // 3. Sustained write then drain past empty
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            din = (i + 1 > 300) ? 16'h012C : 16'(i + 1);
            tick();
            chk("sw wr_ack", 32'(wr_ack), 32'd1);
            chk("sw overflow", 32'(overflow), 32'd0);
        end
        wr_en = 1'b0;
        chk("sw wr_cnt", 32'(wr_data_count), 32'd400);
        chk("sw rd_cnt", 32'(rd_data_count), 32'd800);
        chk("sw full", 32'(full), 32'd0);
        chk("sw prog_full", 32'(prog_full), 32'd0);
        rd_en = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (k < 800) begin
                w = (k / 2 + 1 > 300) ? 16'h012C : 16'(k / 2 + 1);
                b = (k % 2 == 1) ? w[7:0] : w[15:8];
                chk("sw rd valid", 32'(valid), 32'd1);
                chk("sw rd dout", 32'(dout), 32'(b));
            end else begin
                chk("sw udf valid", 32'(valid), 32'd0);
                chk("sw udf underflow", 32'(underflow), 32'd1);
                chk("sw udf dout hold", 32'(dout), 32'h2C);
            end
        end
        rd_en = 1'b0;

        // 4. Fill and overflow
        do_reset();
        wr_en = 1'b1;
        for (int n = 1; n <= 512; n++) begin
            din = fill_word(n - 1);
            tick();
            if (n == 499) chk("fill pf@499", 32'(prog_full), 32'd0);
            if (n == 500) chk("fill pf@500", 32'(prog_full), 32'd1);
            if (n == 510) chk("fill af@510", 32'(almost_full), 32'd0);
            if (n == 511) begin
                chk("fill af@511", 32'(almost_full), 32'd1);
                chk("fill full@511", 32'(full), 32'd0);
            end
        end
        chk("fill full", 32'(full), 32'd1);
        chk("fill wr_cnt wrap", 32'(wr_data_count), 32'd0);
        chk("fill rd_cnt wrap", 32'(rd_data_count), 32'd0);
        din = 16'hDEAD;
        tick();
        wr_en = 1'b0;
        chk("ovf overflow", 32'(overflow), 32'd1);
        chk("ovf wr_ack", 32'(wr_ack), 32'd0);
        chk("ovf full", 32'(full), 32'd1);
        rd_en = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            tick();
            w = fill_word(k / 2);
            b = (k % 2 == 1) ? w[7:0] : w[15:8];
            chk("fill rd dout", 32'(dout), 32'(b));
        end
        rd_en = 1'b0;
        chk("fill drained empty", 32'(empty), 32'd1);

        // 5. Simultaneous access at 100 words
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            din = 16'(i);
            tick();
        end
        rd_en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            din = 16'(100 + j);
            tick();
            b = (j % 2 == 1) ? 8'(j / 2) : 8'h00;
            chk("sim dout", 32'(dout), 32'(b));
        end
        rd_en = 1'b0;
        chk("sim wr_cnt", 32'(wr_data_count), 32'd110);
        chk("sim rd_cnt", 32'(rd_data_count), 32'd220);
        for (int k = 0; k < 402; k++) begin
            din = 16'(120 + k);
            tick();
        end
        chk("sim full", 32'(full), 32'd1);
        rd_en = 1'b1; din = 16'hBEEF;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("simf overflow", 32'(overflow), 32'd1);
        chk("simf wr_ack", 32'(wr_ack), 32'd0);
        chk("simf valid", 32'(valid), 32'd1);
        chk("simf dout", 32'(dout), 32'h00);
        chk("simf rd_cnt", 32'(rd_data_count), 32'd1023);
        chk("simf full", 32'(full), 32'd1);

        // 6. Reset mid-burst
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            din = 16'(16'h0A00 + i);
            tick();
        end
        chk("mid wr_cnt50", 32'(wr_data_count), 32'd50);
        rd_en = 1'b1; srst = 1'b1; din = 16'h7777;
        tick();
        srst = 1'b0; wr_en = 1'b0;
        chk_reset_state("mid reset");
        tick();
        rd_en = 1'b0;
        chk("mid post underflow", 32'(underflow), 32'd1);
        chk("mid post valid", 32'(valid), 32'd0);
        chk("mid post empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
